// File: rtl/lif_neuron_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron.
//   - default parameter values for the neuron and its interface
//   - lif_state_t: neuron FSM state encoding (INTEG / REFRAC)
//   - clamp_u: saturate a signed value into the range [0, hi]
package lif_neuron_pkg;

   localparam int N_IN_DEF       = 4;
   localparam int W_W_DEF        = 8;
   localparam int ACC_W_DEF      = 12;
   localparam int LEAK_SHIFT_DEF = 3;
   localparam int REFRAC_CYC_DEF = 2;

   typedef enum logic {
      INTEG  = 1'b0,
      REFRAC = 1'b1
   } lif_state_t;

   // Saturate both ends. The caller sign-extends into 32 bits and truncates
   // the result back to its own width, so one helper serves every ACC_W.
   function automatic logic [31:0] clamp_u(input logic signed [31:0] x,
                                           input logic        [31:0] hi);
      if (x < 32'sd0) begin
         return 32'd0;
      end
      if ($unsigned(x) > hi) begin
         return hi;
      end
      return $unsigned(x);
   endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// Neuron bus: step qualifier, synaptic inputs and threshold towards the
// neuron, spike / membrane / refractory status back from it.
//   master : drives en, in_spikes, weights, threshold; observes outputs
//   slave  : the neuron itself
// Handshake: there is no valid/ready pair. en is a per-cycle step qualifier:
// a cycle with en=1 at a rising clock edge is one time step and consumes the
// inputs present at that edge; a cycle with en=0 freezes the neuron and
// forces spike low. The neuron can never stall, so there is no ready.
interface lif_neuron_if
   import lif_neuron_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int W_W   = W_W_DEF,
   parameter int ACC_W = ACC_W_DEF
);
   logic                   en;
   logic [N_IN-1:0]        in_spikes;
   logic [N_IN*W_W-1:0]    weights;
   logic [ACC_W-1:0]       threshold;
   logic                   spike;
   logic [ACC_W-1:0]       membrane;
   logic                   refractory;

   modport master (
      output en, in_spikes, weights, threshold,
      input  spike, membrane, refractory
   );

   modport slave (
      input  en, in_spikes, weights, threshold,
      output spike, membrane, refractory
   );
endinterface

// File: rtl/lif_neuron_synapse_sum.sv
// Combinational gated signed sum of synaptic weights.
//   in_spikes_i : bit i enables weight i
//   weights_i   : packed two's-complement weights, weight i at [i*W_W +: W_W]
//   syn_o       : signed sum, wide enough that N_IN full-scale weights never overflow
module lif_neuron_synapse_sum
   import lif_neuron_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int W_W   = W_W_DEF,
   parameter int SYN_W = W_W + $clog2(N_IN) + 1
) (
   input  logic [N_IN-1:0]          in_spikes_i,
   input  logic [N_IN*W_W-1:0]      weights_i,
   output logic signed [SYN_W-1:0]  syn_o
);

   logic signed [SYN_W-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (in_spikes_i[i]) begin
            // Size cast of a signed operand sign-extends the weight.
            acc = acc + SYN_W'($signed(weights_i[i*W_W +: W_W]));
         end
      end
      syn_o = acc;
   end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   nrn     : neuron bus (slave side): en, in_spikes, weights, threshold in;
//             spike, membrane, refractory out (all outputs registered)
//   state_o : current FSM state for observation
// Each enabled step in INTEG: v <- clamp(v - (v >> LEAK_SHIFT) + syn). Reaching
// the threshold fires a one-cycle spike, zeroes v and spends REFRAC_CYC enabled
// steps in REFRAC ignoring inputs.
module lif_neuron
   import lif_neuron_pkg::*;
#(
   parameter int N_IN       = N_IN_DEF,
   parameter int W_W        = W_W_DEF,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
   parameter int REFRAC_CYC = REFRAC_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   lif_neuron_if.slave nrn,
   output lif_state_t  state_o
);

   localparam int SYN_W = W_W + $clog2(N_IN) + 1;
   localparam int T_W   = ACC_W + 2;
   localparam int CNT_W = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
   localparam logic [31:0] ACC_MAX = 32'((64'd1 << ACC_W) - 64'd1);

   lif_state_t               state_q, state_d;
   logic [ACC_W-1:0]         v_q, v_d;
   logic                     spike_q, spike_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;

   logic signed [SYN_W-1:0]  syn;
   logic [ACC_W-1:0]         leak;
   logic signed [T_W-1:0]    t;
   logic [ACC_W-1:0]         v_n;
   logic                     fire;

   lif_neuron_synapse_sum #(
      .N_IN  (N_IN),
      .W_W   (W_W),
      .SYN_W (SYN_W)
   ) u_syn (
      .in_spikes_i (nrn.in_spikes),
      .weights_i   (nrn.weights),
      .syn_o       (syn)
   );

   // A zero shift would leak the whole potential, so LEAK_SHIFT==0 means no leak.
   assign leak = (LEAK_SHIFT == 0) ? '0 : (v_q >> LEAK_SHIFT);

   // v - leak is never negative; two guard bits hold both the overshoot above
   // 2^ACC_W-1 and the undershoot below 0 before clamping.
   assign t    = $signed({2'b00, v_q - leak}) + T_W'(syn);
   assign v_n  = ACC_W'(clamp_u(32'(t), ACC_MAX));
   assign fire = (v_n >= nrn.threshold);

   // State register (plus datapath registers)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= INTEG;
         v_q     <= '0;
         spike_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         spike_q <= spike_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (nrn.en) begin
         unique case (state_q)
            INTEG:  if (fire && (REFRAC_CYC != 0)) state_d = REFRAC;
            REFRAC: if (cnt_q == CNT_W'(1))        state_d = INTEG;
            default: state_d = INTEG;
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      v_d     = v_q;
      spike_d = 1'b0;
      cnt_d   = cnt_q;
      if (nrn.en) begin
         unique case (state_q)
            INTEG: begin
               if (fire) begin
                  v_d     = '0;
                  spike_d = 1'b1;
                  // With REFRAC_CYC==0 this loads 0 and the FSM stays in INTEG.
                  cnt_d   = CNT_W'(REFRAC_CYC);
               end else begin
                  v_d = v_n;
               end
            end
            REFRAC: begin
               v_d   = '0;
               cnt_d = cnt_q - CNT_W'(1);
            end
            default: begin
               v_d   = '0;
               cnt_d = '0;
            end
         endcase
      end
   end

   assign nrn.spike      = spike_q;
   assign nrn.membrane   = v_q;
   assign nrn.refractory = (state_q == REFRAC);
   assign state_o        = state_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: three instances with different leak / refractory
// parameters share one stimulus. A step-level model predicts every output
// each enabled or disabled cycle; directed sequences pin literal values.
module tb_lif_neuron;
   import lif_neuron_pkg::*;

   localparam int ND = 3;
   localparam int EW = 14;   // per-DUT expectation: {spike, refractory, membrane[11:0]}

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [3:0]  in_spikes;
   logic [31:0] weights;
   logic [11:0] threshold;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-instance parameters: u0 leak 3 / refrac 2, u1 no leak / refrac 2, u2 leak 1 / no refrac
   int ls_tab[ND] = '{3, 0, 1};
   int rc_tab[ND] = '{2, 2, 0};

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   lif_neuron_if #(.N_IN(4), .W_W(8), .ACC_W(12)) if0 ();
   lif_neuron_if #(.N_IN(4), .W_W(8), .ACC_W(12)) if1 ();
   lif_neuron_if #(.N_IN(4), .W_W(8), .ACC_W(12)) if2 ();

   assign if0.en = en; assign if0.in_spikes = in_spikes; assign if0.weights = weights; assign if0.threshold = threshold;
   assign if1.en = en; assign if1.in_spikes = in_spikes; assign if1.weights = weights; assign if1.threshold = threshold;
   assign if2.en = en; assign if2.in_spikes = in_spikes; assign if2.weights = weights; assign if2.threshold = threshold;

   lif_state_t st0, st1, st2;

   lif_neuron #(.N_IN(4), .W_W(8), .ACC_W(12), .LEAK_SHIFT(3), .REFRAC_CYC(2)) u0 (
      .clk(clk), .rst_n(rst_n), .nrn(if0), .state_o(st0));
   lif_neuron #(.N_IN(4), .W_W(8), .ACC_W(12), .LEAK_SHIFT(0), .REFRAC_CYC(2)) u1 (
      .clk(clk), .rst_n(rst_n), .nrn(if1), .state_o(st1));
   lif_neuron #(.N_IN(4), .W_W(8), .ACC_W(12), .LEAK_SHIFT(1), .REFRAC_CYC(0)) u2 (
      .clk(clk), .rst_n(rst_n), .nrn(if2), .state_o(st2));

   logic        act_sp[ND];
   logic        act_rf[ND];
   logic [11:0] act_mv[ND];
   assign act_sp[0] = if0.spike; assign act_rf[0] = if0.refractory; assign act_mv[0] = if0.membrane;
   assign act_sp[1] = if1.spike; assign act_rf[1] = if1.refractory; assign act_mv[1] = if1.membrane;
   assign act_sp[2] = if2.spike; assign act_rf[2] = if2.refractory; assign act_mv[2] = if2.membrane;

   // ---------------- checker ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  mv[ND];
   int  mrc[ND];     // refractory steps still owed
   bit  msp[ND];
   logic [ND*EW-1:0] exp_q[$];

   function automatic int syn_of(input logic [3:0] s, input logic [31:0] w);
      int  sum;
      byte b;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         b = w[i*8 +: 8];
         if (s[i]) sum += b;
      end
      return sum;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [ND*EW-1:0] ent;
      int t;
      if (!rst_n) begin
         for (int k = 0; k < ND; k++) begin
            mv[k] = 0; mrc[k] = 0; msp[k] = 0;
         end
         exp_q.delete();
      end else begin
         ent = '0;
         for (int k = 0; k < ND; k++) begin
            if (!en) begin
               msp[k] = 0;
            end else if (mrc[k] > 0) begin
               mrc[k] = mrc[k] - 1;
               mv[k]  = 0;
               msp[k] = 0;
            end else begin
               t = mv[k] - ((ls_tab[k] == 0) ? 0 : (mv[k] >> ls_tab[k])) + syn_of(in_spikes, weights);
               if (t < 0)    t = 0;
               if (t > 4095) t = 4095;
               if (t >= int'(threshold)) begin
                  mv[k] = 0; msp[k] = 1; mrc[k] = rc_tab[k];
               end else begin
                  mv[k] = t; msp[k] = 0;
               end
            end
            ent[k*EW +: EW] = {msp[k], (mrc[k] > 0), 12'(mv[k])};
         end
         exp_q.push_back(ent);
      end
   end

   // ---------------- scoreboard compare (every cycle, away from the edge) ----------------
   logic [ND*EW-1:0] e_cmp;
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         e_cmp = exp_q.pop_front();
         for (int k = 0; k < ND; k++) begin
            chk($sformatf("u%0d_spike", k), int'(act_sp[k]), int'(e_cmp[k*EW + 13]));
            chk($sformatf("u%0d_refractory", k), int'(act_rf[k]), int'(e_cmp[k*EW + 12]));
            chk($sformatf("u%0d_membrane", k), int'(act_mv[k]), int'(e_cmp[k*EW +: 12]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Asserts reset between clock edges and checks outputs clear with no edge.
   task automatic do_reset();
      en = 1'b0; in_spikes = '0;
      rst_n = 1'b0;
      #2;
      for (int k = 0; k < ND; k++) begin
         chk($sformatf("rst_u%0d_spike", k), int'(act_sp[k]), 0);
         chk($sformatf("rst_u%0d_membrane", k), int'(act_mv[k]), 0);
         chk($sformatf("rst_u%0d_refractory", k), int'(act_rf[k]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic step(input logic e, input logic [3:0] s, input logic [31:0] w, input logic [11:0] thr);
      en = e; in_spikes = s; weights = w; threshold = thr;
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      en = 1'b0; in_spikes = '0; weights = '0; threshold = '0;
      do_reset();

      // Integrate without leak: 40, 80, fire, two refractory steps, resume
      step(1'b1, 4'b0001, 32'h0000_0028, 12'd100); chk("t2_m1", act_mv[1], 40);
      step(1'b1, 4'b0001, 32'h0000_0028, 12'd100); chk("t2_m2", act_mv[1], 80);
      step(1'b1, 4'b0001, 32'h0000_0028, 12'd100);
      chk("t2_fire_spike", act_sp[1], 1); chk("t2_fire_m", act_mv[1], 0); chk("t2_fire_rf", act_rf[1], 1);
      step(1'b1, 4'b0001, 32'h0000_0028, 12'd100);
      chk("t2_r1_spike", act_sp[1], 0); chk("t2_r1_rf", act_rf[1], 1); chk("t2_r1_m", act_mv[1], 0);
      step(1'b1, 4'b0001, 32'h0000_0028, 12'd100);
      chk("t2_r2_rf", act_rf[1], 0); chk("t2_r2_m", act_mv[1], 0);
      step(1'b1, 4'b0001, 32'h0000_0028, 12'd100); chk("t2_resume_m", act_mv[1], 40);

      // Leak with floor shifts: 64 -> 56 -> 49 -> 43
      do_reset();
      step(1'b1, 4'b0001, 32'h0000_0040, 12'd4095); chk("t3_preset", act_mv[0], 64);
      step(1'b1, 4'b0000, 32'h0000_0040, 12'd4095); chk("t3_l1", act_mv[0], 56);
      step(1'b1, 4'b0000, 32'h0000_0040, 12'd4095); chk("t3_l2", act_mv[0], 49);
      step(1'b1, 4'b0000, 32'h0000_0040, 12'd4095); chk("t3_l3", act_mv[0], 43);
      chk("t3_model_pin", mv[0], 43);

      // Positive saturation: 8 x 508 = 4064, next step clamps to 4095 and fires (a wrap would give 476)
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095);
      chk("t4_m8", act_mv[1], 4064);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095);
      chk("t4_clamp_fire", act_sp[1], 1); chk("t4_clamp_m", act_mv[1], 0);
      // Negative saturation from v=100
      do_reset();
      step(1'b1, 4'b0001, 32'h0000_0064, 12'd4095); chk("t4_v100", act_mv[1], 100);
      step(1'b1, 4'b1111, 32'h8080_8080, 12'd4095);
      chk("t4_neg_u1", act_mv[1], 0); chk("t4_neg_u0", act_mv[0], 0); chk("t4_neg_sp", act_sp[1], 0);

      // Refractory ignores inputs; en=0 inside REFRAC extends it
      do_reset();
      step(1'b1, 4'b0001, 32'h0000_0064, 12'd100);
      chk("t5_fire", act_sp[1], 1); chk("t5_u2_fire", act_sp[2], 1); chk("t5_u2_norf", act_rf[2], 0);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095);
      chk("t5_r1_m", act_mv[1], 0); chk("t5_r1_rf", act_rf[1], 1); chk("t5_u2_int", act_mv[2], 508);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095);
      chk("t5_r2_m", act_mv[1], 0); chk("t5_r2_rf", act_rf[1], 0);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095); chk("t5_resume", act_mv[1], 508);
      step(1'b1, 4'b0001, 32'h0000_0064, 12'd100);  chk("t5_fire2", act_sp[1], 1);
      step(1'b0, 4'b1111, 32'h7F7F_7F7F, 12'd4095);
      chk("t5_hold_sp", act_sp[1], 0); chk("t5_hold_rf", act_rf[1], 1);
      step(1'b0, 4'b1111, 32'h7F7F_7F7F, 12'd4095); chk("t5_hold2_rf", act_rf[1], 1);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095); chk("t5_ext_rf", act_rf[1], 1);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095); chk("t5_ext_end", act_rf[1], 0);
      step(1'b1, 4'b1111, 32'h7F7F_7F7F, 12'd4095); chk("t5_ext_resume", act_mv[1], 508);

      // Mixed signs, threshold 0: {+10,-30,+5,+20}
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'b1111, 32'h1405_E20A, 12'd0);
         chk($sformatf("t6_u1_sp%0d", i), act_sp[1], (i == 0 || i == 3) ? 1 : 0);
         chk($sformatf("t6_u2_sp%0d", i), act_sp[2], 1);
      end
      step(1'b1, 4'b1111, 32'h1405_E20A, 12'd0);
      chk("t6_mid_rf", act_rf[1], 1);
      do_reset();   // reset asserted mid-REFRAC

      // Randomized phase
      for (int c = 0; c < 3000; c++) begin
         logic [11:0] thr;
         logic [31:0] w;
         case ($urandom_range(0, 3))
            0: thr = 12'd0;
            1: thr = 12'd4095;
            2: thr = 12'($urandom_range(0, 600));
            default: thr = 12'($urandom_range(0, 4095));
         endcase
         case ($urandom_range(0, 7))
            0: w = 32'h7F7F_7F7F;
            1: w = 32'h8080_8080;
            default: w = $urandom();
         endcase
         if ($urandom_range(0, 299) == 0) do_reset();
         step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), w, thr);
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
